// File: rtl/aes_sched_pkg.sv
// Shared types and sizes for the AES S-box scheduler.
// Job selector, FSM state encoding and the byte counts of the two job kinds.
package aes_sched_pkg;

    typedef enum logic {
        ST,
        KW
    } req_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sched_state_t;

    localparam int STATE_BYTES = 16;
    localparam int WORD_BYTES  = 4;

endpackage

// File: rtl/AES_SBOX.sv
// Single AES forward S-box lane: GF(2^8) inverse followed by the affine map.
// The inverse is x^254, built from a short square-and-multiply chain.
module AES_SBOX (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // 254 = 240 + 12 + 2; zero maps to zero without a special case
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gmul(a, a);
        x3   = gmul(x2, a);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        return gmul(gmul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign s_o = affine(ginv(a_i));

endmodule

// File: rtl/aes_sbox_lanes.sv
// NUM_SBOX parallel S-box lanes, purely combinational.
// Lane j maps din_i byte j to dout_o byte j.
module aes_sbox_lanes #(
    parameter int NUM_SBOX = 4
) (
    input  logic [NUM_SBOX*8-1:0] din_i,
    output logic [NUM_SBOX*8-1:0] dout_o
);

    for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
        AES_SBOX u_sbox (
            .a_i (din_i[8*j +: 8]),
            .s_o (dout_o[8*j +: 8])
        );
    end

endmodule

// File: rtl/aes_sbox_scheduler.sv
// Shares NUM_SBOX S-box lanes between state (SubBytes) and key-word (SubWord) jobs.
// Optional macro AES_SBOX_SCHED_KW_PRIO_EN gives key expansion strict priority.
module aes_sbox_scheduler
    import aes_sched_pkg::*;
#(
    parameter int NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req_valid,
    output logic         st_req_ready,
    input  logic [127:0] st_req_data,
    output logic         st_rsp_valid,
    input  logic         st_rsp_ready,
    output logic [127:0] st_rsp_data,
    input  logic         kw_req_valid,
    output logic         kw_req_ready,
    input  logic [31:0]  kw_req_data,
    output logic         kw_rsp_valid,
    input  logic         kw_rsp_ready,
    output logic [31:0]  kw_rsp_data
);

    localparam int LANE_W   = NUM_SBOX * 8;
    localparam int ST_BEATS = STATE_BYTES / NUM_SBOX;
    localparam int KW_BEATS = WORD_BYTES / NUM_SBOX;
    localparam int BEAT_W   = $clog2(ST_BEATS) + 1;

    sched_state_t       state_q, state_d;
    req_sel_t           job_sel_q, job_sel_d;
    req_sel_t           last_grant_q, last_grant_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [127:0]       buf_q, buf_d;

    logic [LANE_W-1:0]  lane_in, lane_out;
    logic               gnt_st, gnt_kw, last_beat, idle;

    assign lane_in = buf_q[int'(beat_q)*LANE_W +: LANE_W];

    aes_sbox_lanes #(.NUM_SBOX(NUM_SBOX)) u_lanes (
        .din_i  (lane_in),
        .dout_o (lane_out)
    );

`ifdef AES_SBOX_SCHED_KW_PRIO_EN
    assign gnt_kw = kw_req_valid;
`else
    assign gnt_kw = kw_req_valid & (~st_req_valid | (last_grant_q == ST));
`endif
    assign gnt_st = st_req_valid & ~gnt_kw;

    assign last_beat = (beat_q == BEAT_W'((job_sel_q == ST) ? ST_BEATS - 1 : KW_BEATS - 1));
    assign idle      = rst_n && (state_q == IDLE);

    // A requester that loses arbitration sees ready low so only the winner handshakes
    assign st_req_ready = idle & ~(st_req_valid & gnt_kw);
    assign kw_req_ready = idle & ~(kw_req_valid & gnt_st);

    assign st_rsp_valid = rst_n && (state_q == DONE) && (job_sel_q == ST);
    assign kw_rsp_valid = rst_n && (state_q == DONE) && (job_sel_q == KW);
    assign st_rsp_data  = st_rsp_valid ? buf_q : '0;
    assign kw_rsp_data  = kw_rsp_valid ? buf_q[31:0] : '0;

    always_comb begin
        state_d      = state_q;
        job_sel_d    = job_sel_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        buf_d        = buf_q;
        case (state_q)
            IDLE: begin
                if (gnt_st || gnt_kw) begin
                    job_sel_d    = gnt_kw ? KW : ST;
                    last_grant_d = gnt_kw ? KW : ST;
                    beat_d       = '0;
                    buf_d        = gnt_kw ? {96'b0, kw_req_data} : st_req_data;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                buf_d[int'(beat_q)*LANE_W +: LANE_W] = lane_out;
                beat_d = beat_q + 1'b1;
                if (last_beat) state_d = DONE;
            end
            DONE: begin
                if ((job_sel_q == ST && st_rsp_ready) || (job_sel_q == KW && kw_rsp_ready))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            job_sel_q    <= ST;
            last_grant_q <= ST;
            beat_q       <= '0;
            buf_q        <= '0;
        end else begin
            state_q      <= state_d;
            job_sel_q    <= job_sel_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            buf_q        <= buf_d;
        end
    end

endmodule
